window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Upstream neighbour of the 3x3 colour filter stage.
- Accepts a raster-order RGB444 pixel stream, one pixel per accepted beat.
- Buffers two image lines and assembles the 3x3 neighbourhood of each interior pixel.
- Presents the neighbourhood as one packed 108-bit word plus a valid strobe, in the field order the filter consumes.

Parameters:
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)
PIX_W, 12, bits per pixel (RGB444); all widths below assume 12

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pix_in  input  12  pixel {R[11:8],G[7:4],B[3:0]}
pix_valid  input  1  pix_in accepted this cycle
sof  input  1  qualifies pix_in as pixel (0,0) of a new frame; ignored unless pix_valid=1
window_out  output  108  packed 3x3 neighbourhood
window_valid  output  1  window_out valid, one-cycle pulse per window
frame_done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values:
  - window_out=0, window_valid=0, frame_done=0.
  - col/row counters=0.
  - Line buffer contents are don't-care.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the accepted pixel.
  - Advance only on pix_valid.
  - col wraps to 0 and increments row.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- sof with pix_valid forces the accepted pixel to position (0,0); the counters continue from there.
  - Mid-frame sof abandons the partial frame. No windows are emitted for any position of the old frame after that point.
- Two line buffers of IMG_WIDTH x 12:
  - LB1 holds line row-1; LB2 holds line row-2.
  - On accept: read LB1[col] and LB2[col] first, then write LB2[col] <= LB1[col] and LB1[col] <= pix_in. This is read-before-write within the cycle.
- A 3x3 register window shifts left one column per accept.
  - New right column = {LB2[col], LB1[col], pix_in} (top, mid, bottom).
- Window emission:
  - Registered one cycle after accepting pixel (col,row) when col>=2 and row>=2. Latency is 1 clock.
  - The emitted centre is (col-1, row-1), so only interior pixels are emitted: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
- window_out packing (p(x,y)):
  - [107:96] centre p(c,r)
  - [95:84] left p(c-1,r)
  - [83:72] right p(c+1,r)
  - [71:60] up p(c,r-1)
  - [59:48] down p(c,r+1)
  - [47:36] upleft
  - [35:24] upright
  - [23:12] downleft
  - [11:0] downright
- pix_valid=0 is a stall:
  - Nothing shifts and counters hold.
  - window_valid=0 and window_out holds its last value.
- frame_done = window_valid for the window whose accepted pixel was (IMG_WIDTH-1, IMG_HEIGHT-1).
- No backpressure: downstream must accept every window_valid pulse.
- Reset asserted mid-frame:
  - Next cycle all outputs are 0 and counters are 0.
  - The first post-reset pixel is treated as (0,0) regardless of sof.
- Rows 0-1 after a frame start, and col 0-1 of every row, emit nothing. Stale line-buffer data never reaches a valid window.

Optional Feature:
- Macro WINDOW_COORD_EN.
- Defined:
  - Adds outputs center_x (11 bits) and center_y (10 bits), registered together with window_out.
  - They carry (col-1, row-1) of the emitted window and reset to 0.
- Undefined:
  - Ports absent; no coordinate registers.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, continuous pix_valid, sof on first pixel, pix_in = row*16+col -> exactly 6 window_valid pulses.
  - First pulse one clock after pixel (2,2).
  - window_out = {011,010,012,001,021,000,002,020,022} (hex fields, MSB first).
  - frame_done only with the 6th pulse.
- Same frame with pix_valid deasserted every other cycle -> identical 6 windows in order; window_out stable during stall cycles.
- Two back-to-back frames, second with pix_in+0x100 -> second frame's first window centre = 0x111; no window mixes frame-1 and frame-2 rows in positions emitted.
- sof reasserted at pixel (3,2) of frame 1 -> no further frame-1 windows; the new frame produces 6 correct windows.
- reset asserted for 1 cycle at pixel (1,3) -> outputs 0 next cycle; the following 20 pixels (no sof) yield 6 correct windows.
- WINDOW_COORD_EN defined, 5x4 frame -> (center_x,center_y) sequence (1,1),(2,1),(3,1),(1,2),(2,2),(3,2).

Source files
------------

// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//   Turns a raster-order RGB444 pixel stream into the 3x3 neighbourhood of
//   every interior pixel. Two line buffers hold the previous two lines, and a
//   3x3 register window shifts left on each accepted pixel. Each window is
//   emitted one clock after its bottom-right pixel is accepted.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   pix_in       pixel {R[11:8],G[7:4],B[3:0]}
//   pix_valid    pix_in accepted this cycle (0 = stall, nothing moves)
//   sof          with pix_valid, marks the accepted pixel as (0,0)
//   window_out   {c, l, r, u, d, ul, ur, dl, dr}, 12 bits each, centre at MSB
//   window_valid one-cycle pulse per emitted window
//   frame_done   pulses together with the window of pixel (W-1,H-1)
//   center_x/y   (only with WINDOW_COORD_EN) coordinates of the emitted centre
//
// Optional feature: define WINDOW_COORD_EN to add center_x / center_y.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               sof,
  output logic [9*PIX_W-1:0] window_out,
  output logic               window_valid,
  output logic               frame_done
`ifdef WINDOW_COORD_EN
  ,
  output logic [10:0]        center_x,
  output logic [9:0]         center_y
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // col/row hold the position the next accepted pixel will take.
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          restart;

  // sof overrides the counters for the pixel that carries it.
  assign restart = pix_valid & sof;
  assign cur_col = restart ? '0 : col;
  assign cur_row = restart ? '0 : row;

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Line buffers: lb1 = line row-1, lb2 = line row-2. The read happens on the
  // old contents, so the same column is both read and rewritten in one cycle.
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb2 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;

  assign lb1_rd = lb1[cur_col];
  assign lb2_rd = lb2[cur_col];

  always_ff @(posedge clk) begin
    if (pix_valid && !reset) begin
      lb2[cur_col] <= lb1_rd;
      lb1[cur_col] <= pix_in;
    end
  end

  // win[r][c]: r=0 top .. 2 bottom, c=0 left .. 2 right.
  logic [2:0][2:0][PIX_W-1:0] win, nxt;
  logic [2:0][PIX_W-1:0]      new_col;

  assign new_col = {pix_in, lb1_rd, lb2_rd};  // [2]=bottom, [0]=top

  genvar r;
  generate
    for (r = 0; r < 3; r++) begin : g_row
      assign nxt[r] = {new_col[r], win[r][2], win[r][1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)          win <= '0;
    else if (pix_valid) win <= nxt;
  end

  // A window is complete once the accepted pixel sits at col>=2, row>=2:
  // every column in it then belongs to the current frame, so stale line
  // buffer contents after a restart are never exposed.
  logic emit, last_pix;
  assign emit     = pix_valid && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  assign last_pix = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      window_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= emit;
      frame_done   <= emit && last_pix;
      // window_out only changes when a new window goes out.
      if (emit)
        window_out <= {nxt[1][1], nxt[1][0], nxt[1][2],
                       nxt[0][1], nxt[2][1],
                       nxt[0][0], nxt[0][2], nxt[2][0], nxt[2][2]};
    end
  end

`ifdef WINDOW_COORD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      center_x <= '0;
      center_y <= '0;
    end else if (emit) begin
      center_x <= 11'(cur_col) - 11'd1;
      center_y <= 10'(cur_row) - 10'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 5x4 image. A 2-D image model predicts every
// output cycle by cycle; directed frames are also compared against a table of
// hand-derived windows.
module tb_window_3x3_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pix_valid = 1'b0;
  logic         sof = 1'b0;
  logic [11:0]  pix_in = '0;
  logic [107:0] window_out;
  logic         window_valid;
  logic         frame_done;
`ifdef WINDOW_COORD_EN
  logic [10:0]  center_x;
  logic [9:0]   center_y;
`endif

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(12)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .sof          (sof),
    .window_out   (window_out),
    .window_valid (window_valid),
    .frame_done   (frame_done)
`ifdef WINDOW_COORD_EN
    ,
    .center_x     (center_x),
    .center_y     (center_y)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole image in a 2-D array -----------
  logic [11:0]  img [H][W];
  int           mx = 0, my = 0, acc_cnt = 0;
  bit           exp_vld = 0, exp_fd = 0, rst_chk = 0, hold_chk = 0;
  logic [107:0] exp_word = '0;
  int           exp_cx = 0, exp_cy = 0;

  function automatic logic [107:0] mk_win(input int cx, input int cy);
    return {img[cy][cx], img[cy][cx-1], img[cy][cx+1],
            img[cy-1][cx], img[cy+1][cx],
            img[cy-1][cx-1], img[cy-1][cx+1], img[cy+1][cx-1], img[cy+1][cx+1]};
  endfunction

  always @(posedge clk) begin
    rst_chk  = reset;
    hold_chk = 0;
    exp_vld  = 0;
    exp_fd   = 0;
    if (reset) begin
      mx = 0; my = 0;
      exp_word = '0; exp_cx = 0; exp_cy = 0;
    end else if (!pix_valid) begin
      hold_chk = 1;
    end else begin
      acc_cnt++;
      if (sof) begin mx = 0; my = 0; end
      img[my][mx] = pix_in;
      if (mx >= 2 && my >= 2) begin
        exp_vld  = 1;
        exp_word = mk_win(mx - 1, my - 1);
        exp_fd   = (mx == W - 1) && (my == H - 1);
        exp_cx   = mx - 1;
        exp_cy   = my - 1;
      end
      mx++;
      if (mx == W) begin
        mx = 0; my++;
        if (my == H) my = 0;
      end
    end
  end

  // ---------------- monitor + capture ------------------------------------
  typedef struct { logic [107:0] w; logic fd; int nacc; } cap_t;
  cap_t cap [$];

  always @(negedge clk) begin
    chk("window_valid", {107'd0, window_valid}, {107'd0, exp_vld});
    chk("frame_done", {107'd0, frame_done}, {107'd0, exp_fd});
    if (rst_chk)       chk("window_out_reset", window_out, exp_word);
    else if (exp_vld)  chk("window_out", window_out, exp_word);
    else if (hold_chk) chk("window_out_hold", window_out, exp_word);
`ifdef WINDOW_COORD_EN
    if (exp_vld || rst_chk) begin
      chk("center_x", 108'(center_x), 108'(exp_cx));
      chk("center_y", 108'(center_y), 108'(exp_cy));
    end
`endif
    if (window_valid) cap.push_back('{window_out, frame_done, acc_cnt});
  end

  // ---------------- directed table: frame with pix = row*16+col ----------
  typedef struct { int nacc; logic [107:0] w; logic fd; } vec_t;
  vec_t tbl [6];

  task automatic check_frame(input string tag, input int first,
                             input logic [107:0] add, input bit use_acc);
    for (int i = 0; i < 6; i++) begin
      if (first + i < cap.size()) begin
        chk({tag, "_win"}, cap[first+i].w, tbl[i].w + add);
        chk({tag, "_fd"}, {107'd0, cap[first+i].fd}, {107'd0, tbl[i].fd});
        if (use_acc) chk({tag, "_latency"}, 108'(cap[first+i].nacc), 108'(tbl[i].nacc));
      end else begin
        chk({tag, "_missing"}, 108'(cap.size()), 108'(first + 6));
      end
    end
  endtask

  task automatic step(input bit pv, input bit sf, input logic [11:0] px, input bit rs);
    pix_valid = pv; sof = sf; pix_in = px; reset = rs;
    @(posedge clk); #1;
    pix_valid = 0; sof = 0; reset = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 12'(i), 0);
  endtask

  task automatic send_frame(input logic [11:0] base, input bit alt);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        step(1, (x == 0 && y == 0), 12'(base + y * 16 + x), 0);
        if (alt) step(0, 0, 12'($urandom), 0);
      end
  endtask

  logic [11:0] ctr;

  initial begin
    tbl[0] = '{13, {12'h011,12'h010,12'h012,12'h001,12'h021,12'h000,12'h002,12'h020,12'h022}, 1'b0};
    tbl[1] = '{14, {12'h012,12'h011,12'h013,12'h002,12'h022,12'h001,12'h003,12'h021,12'h023}, 1'b0};
    tbl[2] = '{15, {12'h013,12'h012,12'h014,12'h003,12'h023,12'h002,12'h004,12'h022,12'h024}, 1'b0};
    tbl[3] = '{18, {12'h021,12'h020,12'h022,12'h011,12'h031,12'h010,12'h012,12'h030,12'h032}, 1'b0};
    tbl[4] = '{19, {12'h022,12'h021,12'h023,12'h012,12'h032,12'h011,12'h013,12'h031,12'h033}, 1'b0};
    tbl[5] = '{20, {12'h023,12'h022,12'h024,12'h013,12'h033,12'h012,12'h014,12'h032,12'h034}, 1'b1};

    repeat (2) @(posedge clk);
    #1 reset = 0;
    idle(3);

    // continuous frame
    cap.delete(); acc_cnt = 0;
    send_frame(12'h000, 0); idle(3);
    chk("cont_count", 108'(cap.size()), 108'd6);
    check_frame("cont", 0, '0, 1);

    // stall every other cycle
    cap.delete(); acc_cnt = 0;
    send_frame(12'h000, 1); idle(3);
    chk("stall_count", 108'(cap.size()), 108'd6);
    check_frame("stall", 0, '0, 1);

    // back-to-back frames, second offset by 0x100
    cap.delete();
    send_frame(12'h000, 0); send_frame(12'h100, 0); idle(3);
    chk("b2b_count", 108'(cap.size()), 108'd12);
    if (cap.size() > 6) begin
      ctr = cap[6].w[107:96];
      chk("b2b_centre", 108'(ctr), 108'h111);
    end
    check_frame("b2b", 6, {9{12'h100}}, 0);

    // sof reasserted at (3,2): old frame stops after the (2,2) window
    cap.delete();
    for (int i = 0; i < 13; i++) step(1, i == 0, 12'(12'h500 + (i / W) * 16 + (i % W)), 0);
    send_frame(12'h000, 0); idle(3);
    chk("resof_count", 108'(cap.size()), 108'd7);
    check_frame("resof", 1, '0, 0);

    // reset on pixel (1,3), then 20 pixels without sof
    cap.delete();
    for (int i = 0; i < 16; i++) step(1, i == 0, 12'(12'h700 + (i / W) * 16 + (i % W)), 0);
    step(1, 0, 12'h731, 1);
    cap.delete(); acc_cnt = 0;
    for (int i = 0; i < 20; i++) step(1, 0, 12'((i / W) * 16 + (i % W)), 0);
    idle(3);
    chk("rst_count", 108'(cap.size()), 108'd6);
    check_frame("rst", 0, '0, 1);

    // random traffic: random pixels, stalls, occasional sof and reset
    step(1, 1, 12'($urandom), 0);
    for (int i = 0; i < 600; i++) begin
      bit pv, sf, rs;
      pv = ($urandom_range(0, 9) < 7);
      sf = pv && ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(pv, sf, 12'($urandom), rs);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
